// File: rtl/ps_mem_arbiter_pkg.sv
// Shared definitions for the single-port SRAM arbiter: FSM state encoding and
// counter sizing for the fixed-latency read sequencer.
package ps_mem_arbiter_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IM_RD = 2'd1;
  localparam logic [1:0] S_DM_RD = 2'd2;

  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

endpackage

// File: rtl/ps_mem_arbiter.sv
// Shares one single-port SRAM between the instruction fetch port and the data
// load/store port; one access at a time, fixed-latency reads, per-port stalls.
module ps_mem_arbiter
  import ps_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  im_rd,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_r_data,
  output logic                  im_stall,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  dm_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  fair;
  logic [DATA_WIDTH-1:0] im_hold;
  logic [DATA_WIDTH-1:0] dm_hold;
  logic                  dm_req;
  logic                  grant_im;
  logic                  grant_dm;
  logic                  dm_load;
  logic                  rd_done;

  // DM normally wins; a pending fetch that was passed over by a DM access wins next.
  assign dm_req   = dm_rd | dm_wr;
  assign grant_im = (state == S_IDLE) && im_rd && (fair || !dm_req);
  assign grant_dm = (state == S_IDLE) && dm_req && !grant_im;
  assign dm_load  = grant_dm && !dm_wr;
  assign rd_done  = (state != S_IDLE) && (cnt == LAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_im) begin
          state_nxt = S_IM_RD;
        end else if (dm_load) begin
          state_nxt = S_DM_RD;
        end
      end
      S_IM_RD, S_DM_RD: begin
        if (rd_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    im_r_data  = im_hold;
    dm_r_data  = dm_hold;
    im_stall   = im_rd;
    dm_stall   = dm_req;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (grant_im) begin
            mem_en   = 1'b1;
            mem_addr = im_addr;
          end else if (grant_dm) begin
            mem_en   = 1'b1;
            mem_addr = dm_addr;
            if (dm_wr) begin
              mem_we     = 1'b1;
              mem_w_data = dm_w_data;
              dm_stall   = 1'b0;
            end
          end
        end
        S_IM_RD: begin
          if (rd_done) begin
            im_stall  = 1'b0;
            im_r_data = mem_r_data;
          end
        end
        S_DM_RD: begin
          if (rd_done) begin
            dm_stall  = 1'b0;
            dm_r_data = mem_r_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Latency counter, fairness flag and last-returned-word hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      fair    <= 1'b0;
      im_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (grant_im || dm_load) begin
        cnt <= CNT_W'(1);
      end else if (state != S_IDLE) begin
        cnt <= rd_done ? '0 : cnt + CNT_W'(1);
      end

      if (grant_im) begin
        fair <= 1'b0;
      end else if (grant_dm && dm_wr && im_rd) begin
        fair <= 1'b1;
      end else if (state == S_DM_RD && rd_done && im_rd) begin
        fair <= 1'b1;
      end

      if (state == S_IM_RD && rd_done) begin
        im_hold <= mem_r_data;
      end
      if (state == S_DM_RD && rd_done) begin
        dm_hold <= mem_r_data;
      end
    end
  end

endmodule
